// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;
   typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_e;
   localparam int         MDU_LATENCY_DEFAULT = 4;
   localparam logic [4:0] REG_ZERO            = 5'd0;
endpackage

// File: rtl/mdu_latency_counter.sv
// Loadable down-counter with zero detect, paces the MDU stall window.
module mdu_latency_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (dec && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use bubble, branch flush and MDU hold controller for the 5-stage pipe.
// Optional perf counters (StallCycles, FlushCount) under HAZARD_STALL_PERF_EN.
module hazard_stall_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  IFID_Rs,
   input  logic [4:0]  IFID_Rt,
   input  logic [4:0]  IDEX_Rt,
   input  logic        IDEX_MemRead,
   input  logic        IDEX_MduOp,
   input  logic        BranchTaken,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        IDEXWrite,
   output logic        IFID_Flush,
   output logic        IDEX_Flush,
   output logic        EXMEM_Flush,
   output logic        MduStart,
   output logic        MduBusy
`ifdef HAZARD_STALL_PERF_EN
   ,
   output logic [31:0] StallCycles,
   output logic [15:0] FlushCount
`endif
);
   // The start cycle is the first stall cycle, so BUSY holds MDU_LATENCY-1 more.
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MDU_LATENCY - 1);

   state_e state_q, state_d;
   logic   cnt_load, cnt_dec, cnt_zero, load_use;

   mdu_latency_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (LOAD_VAL),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   assign load_use = IDEX_MemRead && (IDEX_Rt != REG_ZERO) &&
                     ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

   always_comb begin
      state_d     = state_q;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      PCWrite     = 1'b1;
      IFIDWrite   = 1'b1;
      IDEXWrite   = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Flush  = 1'b0;
      EXMEM_Flush = 1'b0;
      MduStart    = 1'b0;
      MduBusy     = 1'b0;
      if (!reset) begin
         case (state_q)
            RUN: begin
               if (IDEX_MduOp) begin
                  MduStart    = 1'b1;
                  PCWrite     = 1'b0;
                  IFIDWrite   = 1'b0;
                  IDEXWrite   = 1'b0;
                  EXMEM_Flush = 1'b1;
                  cnt_load    = 1'b1;
                  state_d     = BUSY;
               end else if (BranchTaken) begin
                  IFID_Flush = 1'b1;
                  IDEX_Flush = 1'b1;
               end else if (load_use) begin
                  PCWrite    = 1'b0;
                  IFIDWrite  = 1'b0;
                  IDEX_Flush = 1'b1;
               end
            end
            BUSY: begin
               MduBusy = 1'b1;
               if (!cnt_zero) begin
                  PCWrite     = 1'b0;
                  IFIDWrite   = 1'b0;
                  IDEXWrite   = 1'b0;
                  EXMEM_Flush = 1'b1;
                  cnt_dec     = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   mdu_branch_exclusive: assert property (@(posedge clk) disable iff (reset)
      (state_q == RUN) |-> !(IDEX_MduOp && BranchTaken));

`ifdef HAZARD_STALL_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (!PCWrite && stall_cycles_q != '1)
         stall_cycles_d = stall_cycles_q + 32'd1;
      if (IFID_Flush && flush_count_q != '1)
         flush_count_d = flush_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign StallCycles = stall_cycles_q;
   assign FlushCount  = flush_count_q;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl; perf counters checked under HAZARD_STALL_PERF_EN.
module tb_hazard_stall_ctrl;
   // {PCWrite,IFIDWrite,IDEXWrite,IFID_Flush,IDEX_Flush,EXMEM_Flush,MduStart,MduBusy}
   localparam logic [7:0] IDLE = 8'b1110_0000;
   localparam logic [7:0] LU   = 8'b0010_1000;
   localparam logic [7:0] BR   = 8'b1111_1000;
   localparam logic [7:0] MST  = 8'b0000_0110;
   localparam logic [7:0] BSY  = 8'b0000_0101;
   localparam logic [7:0] REL  = 8'b1110_0001;

   typedef struct {
      string      nm;
      logic       rst, mr, mop, br;
      logic [4:0] xrt, rs, rt;
      logic [7:0] exp;
   } step_t;

   logic       clk = 1'b0, reset = 1'b1;
   logic [4:0] IFID_Rs = '0, IFID_Rt = '0, IDEX_Rt = '0;
   logic       IDEX_MemRead = 1'b0, IDEX_MduOp = 1'b0, BranchTaken = 1'b0;
   logic       PCWrite, IFIDWrite, IDEXWrite, IFID_Flush, IDEX_Flush, EXMEM_Flush, MduStart, MduBusy;
   logic [7:0] outs, got, e;
   int         n_pass = 0, n_total = 0;
   logic [7:0] sb[$];
`ifdef HAZARD_STALL_PERF_EN
   logic [31:0] StallCycles;
   logic [15:0] FlushCount;
`endif

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MDU_LATENCY(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IDEX_Rt(IDEX_Rt),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_MduOp(IDEX_MduOp), .BranchTaken(BranchTaken),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
      .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
      .MduStart(MduStart), .MduBusy(MduBusy)
`ifdef HAZARD_STALL_PERF_EN
      , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
   );

   assign outs = {PCWrite, IFIDWrite, IDEXWrite, IFID_Flush, IDEX_Flush, EXMEM_Flush, MduStart, MduBusy};

   function automatic step_t mk(string nm, logic rst, logic mr, logic mop, logic br,
                                logic [4:0] xrt, logic [4:0] rs, logic [4:0] rt, logic [7:0] exp);
      step_t s;
      s.nm = nm; s.rst = rst; s.mr = mr; s.mop = mop; s.br = br;
      s.xrt = xrt; s.rs = rs; s.rt = rt; s.exp = exp;
      return s;
   endfunction

   task automatic apply(input step_t s);
      @(posedge clk); #1;
      reset = s.rst; IDEX_MemRead = s.mr; IDEX_MduOp = s.mop; BranchTaken = s.br;
      IDEX_Rt = s.xrt; IFID_Rs = s.rs; IFID_Rt = s.rt;
      sb.push_back(s.exp);
   endtask

   task automatic test_reset();
      step_t st[$];
      st.push_back(mk("reset_cycle", 1, 1, 0, 0, 5'd8, 5'd8, 5'd0, IDLE));
      st.push_back(mk("after_reset", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, IDLE));
      foreach (st[i]) begin
         apply(st[i]); @(negedge clk);
         got = outs; e = sb.pop_front(); n_total++;
         if (got !== e) $display("FAIL %s step %0d: got %b want %b", st[i].nm, i, got, e);
         else n_pass++;
      end
   endtask

   task automatic test_load_use();
      step_t st[$];
      st.push_back(mk("lu_rt",        0, 1, 0, 0, 5'd8, 5'd1, 5'd8, LU));
      st.push_back(mk("lu_bubble",    0, 0, 0, 0, 5'd0, 5'd1, 5'd8, IDLE));
      st.push_back(mk("lu_rs",        0, 1, 0, 0, 5'd9, 5'd9, 5'd2, LU));
      st.push_back(mk("lu_nomatch",   0, 1, 0, 0, 5'd9, 5'd3, 5'd4, IDLE));
      st.push_back(mk("lu_notload",   0, 0, 0, 0, 5'd9, 5'd9, 5'd9, IDLE));
      st.push_back(mk("lu_zero_reg",  0, 1, 0, 0, 5'd0, 5'd0, 5'd0, IDLE));
      foreach (st[i]) begin
         apply(st[i]); @(negedge clk);
         got = outs; e = sb.pop_front(); n_total++;
         if (got !== e) $display("FAIL %s step %0d: got %b want %b", st[i].nm, i, got, e);
         else n_pass++;
      end
   endtask

   task automatic test_branch();
      step_t st[$];
      st.push_back(mk("br_over_lu", 0, 1, 0, 1, 5'd8, 5'd8, 5'd8, BR));
      st.push_back(mk("br_plain",   0, 0, 0, 1, 5'd0, 5'd0, 5'd0, BR));
      st.push_back(mk("br_after",   0, 0, 0, 0, 5'd0, 5'd0, 5'd0, IDLE));
      foreach (st[i]) begin
         apply(st[i]); @(negedge clk);
         got = outs; e = sb.pop_front(); n_total++;
         if (got !== e) $display("FAIL %s step %0d: got %b want %b", st[i].nm, i, got, e);
         else n_pass++;
      end
   endtask

   task automatic test_mdu();
      step_t st[$];
      st.push_back(mk("mdu_start",   0, 0, 1, 0, 5'd0, 5'd0, 5'd0, MST));
      st.push_back(mk("mdu_busy1",   0, 1, 1, 0, 5'd8, 5'd8, 5'd0, BSY));
      st.push_back(mk("mdu_busy2",   0, 0, 1, 0, 5'd0, 5'd0, 5'd0, BSY));
      st.push_back(mk("mdu_busy3",   0, 0, 1, 0, 5'd0, 5'd0, 5'd0, BSY));
      st.push_back(mk("mdu_release", 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, REL));
      st.push_back(mk("mdu_idle",    0, 0, 0, 0, 5'd0, 5'd0, 5'd0, IDLE));
      foreach (st[i]) begin
         apply(st[i]); @(negedge clk);
         got = outs; e = sb.pop_front(); n_total++;
         if (got !== e) $display("FAIL %s step %0d: got %b want %b", st[i].nm, i, got, e);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      step_t st[$];
      for (int k = 0; k < 2; k++) begin
         st.push_back(mk("b2b_start", 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, MST));
         for (int j = 0; j < 3; j++)
            st.push_back(mk("b2b_busy", 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, BSY));
         st.push_back(mk("b2b_release", 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, REL));
      end
      st.push_back(mk("b2b_idle", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, IDLE));
      foreach (st[i]) begin
         apply(st[i]); @(negedge clk);
         got = outs; e = sb.pop_front(); n_total++;
         if (got !== e) $display("FAIL %s step %0d: got %b want %b", st[i].nm, i, got, e);
         else n_pass++;
      end
   endtask

   task automatic test_reset_busy();
      step_t st[$];
      st.push_back(mk("rb_start",  0, 0, 1, 0, 5'd0, 5'd0, 5'd0, MST));
      st.push_back(mk("rb_busy",   0, 0, 1, 0, 5'd0, 5'd0, 5'd0, BSY));
      st.push_back(mk("rb_reset",  1, 0, 1, 0, 5'd0, 5'd0, 5'd0, IDLE));
      st.push_back(mk("rb_run",    0, 0, 0, 0, 5'd0, 5'd0, 5'd0, IDLE));
      st.push_back(mk("rh_start",  0, 0, 1, 0, 5'd0, 5'd0, 5'd0, MST));
      st.push_back(mk("rh_busy",   0, 0, 1, 0, 5'd0, 5'd0, 5'd0, BSY));
      st.push_back(mk("rh_reset",  1, 0, 1, 0, 5'd0, 5'd0, 5'd0, IDLE));
      st.push_back(mk("rh_restart",0, 0, 1, 0, 5'd0, 5'd0, 5'd0, MST));
      for (int j = 0; j < 3; j++)
         st.push_back(mk("rh_busy2", 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, BSY));
      st.push_back(mk("rh_release",0, 0, 1, 0, 5'd0, 5'd0, 5'd0, REL));
      st.push_back(mk("rh_idle",   0, 0, 0, 0, 5'd0, 5'd0, 5'd0, IDLE));
      foreach (st[i]) begin
         apply(st[i]); @(negedge clk);
         got = outs; e = sb.pop_front(); n_total++;
         if (got !== e) $display("FAIL %s step %0d: got %b want %b", st[i].nm, i, got, e);
         else n_pass++;
      end
   endtask

`ifdef HAZARD_STALL_PERF_EN
   task automatic test_perf();
      step_t st[$];
      st.push_back(mk("pf_reset", 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, IDLE));
      for (int k = 0; k < 3; k++) begin
         st.push_back(mk("pf_lu",   0, 1, 0, 0, 5'd7, 5'd7, 5'd0, LU));
         st.push_back(mk("pf_idle", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, IDLE));
      end
      st.push_back(mk("pf_mst", 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, MST));
      for (int j = 0; j < 3; j++)
         st.push_back(mk("pf_busy", 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, BSY));
      st.push_back(mk("pf_rel",  0, 0, 1, 0, 5'd0, 5'd0, 5'd0, REL));
      for (int k = 0; k < 2; k++) begin
         st.push_back(mk("pf_br",   0, 0, 0, 1, 5'd0, 5'd0, 5'd0, BR));
         st.push_back(mk("pf_idle", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, IDLE));
      end
      foreach (st[i]) begin
         apply(st[i]); @(negedge clk);
         got = outs; e = sb.pop_front(); n_total++;
         if (got !== e) $display("FAIL %s step %0d: got %b want %b", st[i].nm, i, got, e);
         else n_pass++;
      end
      @(posedge clk); #1;
      n_total++;
      if (StallCycles !== 32'd7) $display("FAIL perf_stall_cycles: got %0d want 7", StallCycles);
      else n_pass++;
      n_total++;
      if (FlushCount !== 16'd2) $display("FAIL perf_flush_count: got %0d want 2", FlushCount);
      else n_pass++;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_mdu();
      test_back_to_back();
      test_reset_busy();
`ifdef HAZARD_STALL_PERF_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
